// File: rtl/udp_pkg.sv
// Shared UDP receive definitions: header geometry, FSM encoding and the
// ones'-complement adder used by the optional checksum (UDP_CSUM_EN).
package udp_pkg;

  localparam int UDP_HEAD_N   = 8;
  localparam int UDP_OFF_DST  = 2;
  localparam int UDP_OFF_LEN  = 4;
  localparam int UDP_OFF_CSUM = 6;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_HEAD  = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_DRAIN = 4'b1000
  } udp_fsm_e;

  // 16-bit ones'-complement add with end-around carry
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/udp_port_match.sv
// Priority comparator over the runtime destination-port table: the lowest
// enabled entry equal to dst wins.
module udp_port_match #(
  parameter int PORT_N = 4,
  parameter int PORT_W = 16,
  parameter int CH_W   = 2
) (
  input  logic [PORT_W-1:0]        dst,
  input  logic [PORT_N*PORT_W-1:0] port_tbl,
  input  logic [PORT_N-1:0]        port_en,
  output logic                     hit,
  output logic [CH_W-1:0]          ch
);

  logic [PORT_N-1:0] eq;

  for (genvar gi = 0; gi < PORT_N; gi++) begin : g_cmp
    assign eq[gi] = port_en[gi] && (port_tbl[gi*PORT_W +: PORT_W] == dst);
  end

  // Scan from the top so the lowest matching index is left in ch
  always_comb begin
    hit = |eq;
    ch  = '0;
    for (int k = PORT_N - 1; k >= 0; k--)
      if (eq[k]) ch = CH_W'(k);
  end

endmodule

// File: rtl/udp_rx_mp.sv
// Multi-port UDP receive parser. Strips the 8-byte header, steers the payload
// to the channel whose port matches, trims IP padding by UDP length and flags
// corrupt packets on the final beat. Payload passes through with no latency.
// Optional feature macro: UDP_CSUM_EN enables UDP checksum verification.
module udp_rx_mp
  import udp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PORT_N = 4,
  parameter int PORT_W = 16,
  parameter int CH_W   = (PORT_N > 1) ? $clog2(PORT_N) : 1,
  localparam int KEEP_W = DATA_W / 8,
  localparam int LEN_W  = $clog2(KEEP_W) + 1
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     cancel_i,
  input  logic                     valid_i,
  input  logic                     start_i,
  input  logic                     last_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     ip_cs_err_i,
  input  logic [15:0]              ip_psum_i,
  input  logic [PORT_N*PORT_W-1:0] port_tbl_i,
  input  logic [PORT_N-1:0]        port_en_i,
  output logic                     valid_o,
  output logic                     start_o,
  output logic                     last_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [LEN_W-1:0]         len_o,
  output logic [CH_W-1:0]          ch_o,
  output logic                     err_o
);

  udp_fsm_e        st_reg;
  logic [15:0]     cnt_reg;
  logic [63:0]     hdr_reg;
  logic [CH_W-1:0] ch_reg;
  logic            first_reg;
  logic            err_reg;

  logic [15:0]     base;
  logic [63:0]     hdr_now;
  logic [16:0]     cnt_sum;
  logic [15:0]     cnt_next;
  logic [15:0]     udp_len;
  logic [PORT_W-1:0] dst;
  logic            hdr_beat, hdr_done, hdr_err, drop, go_data, in_data, reach;
  logic            hit, csum_bad;
  logic [CH_W-1:0] ch_m;

  // Byte offset of the current beat within the UDP datagram
  assign base = (st_reg == ST_IDLE) ? 16'd0 : cnt_reg;

  // Overlay the current beat onto the captured header bytes at the running offset
  always_comb begin
    hdr_now = hdr_reg;
    for (int b = 0; b < UDP_HEAD_N; b++)
      for (int l = 0; l < KEEP_W; l++)
        if (l <= b && base == 16'(b - l))
          hdr_now[8*b +: 8] = data_i[8*l +: 8];
  end

  assign cnt_sum  = {1'b0, base} + 17'(len_i);
  assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  assign udp_len  = {hdr_now[8*UDP_OFF_LEN +: 8], hdr_now[8*UDP_OFF_LEN+8 +: 8]};
  assign dst      = PORT_W'({hdr_now[8*UDP_OFF_DST +: 8], hdr_now[8*UDP_OFF_DST+8 +: 8]});

  assign hdr_beat = valid_i && ((st_reg == ST_IDLE && start_i) || st_reg == ST_HEAD);
  assign hdr_done = hdr_beat && (cnt_sum >= 17'(UDP_HEAD_N));
  assign hdr_err  = ip_cs_err_i || (st_reg == ST_HEAD && err_reg);
  assign drop     = !hit || (udp_len < 16'(UDP_HEAD_N)) || hdr_err;
  assign go_data  = !drop && (udp_len > 16'(UDP_HEAD_N));
  assign in_data  = valid_i && (st_reg == ST_DATA);
  assign reach    = cnt_sum >= {1'b0, udp_len};

  udp_port_match #(
    .PORT_N (PORT_N),
    .PORT_W (PORT_W),
    .CH_W   (CH_W)
  ) u_match (
    .dst      (dst),
    .port_tbl (port_tbl_i),
    .port_en  (port_en_i),
    .hit      (hit),
    .ch       (ch_m)
  );

`ifdef UDP_CSUM_EN
  logic [15:0] csum_reg;
  logic [15:0] beat_sum;
  logic [15:0] csum_acc;
  logic [15:0] csum_fld;
  logic [7:0]  hi_b, lo_b;
  logic        unused_csum;

  // Fold this beat's 16-bit words; bytes past the UDP length count as zero
  always_comb begin
    beat_sum = 16'd0;
    hi_b     = 8'd0;
    lo_b     = 8'd0;
    for (int w = 0; w < KEEP_W / 2; w++) begin
      hi_b = data_i[16*w +: 8];
      lo_b = data_i[16*w+8 +: 8];
      if (st_reg == ST_DATA) begin
        if ({1'b0, cnt_reg} + 17'(2*w) >= {1'b0, udp_len})     hi_b = 8'd0;
        if ({1'b0, cnt_reg} + 17'(2*w + 1) >= {1'b0, udp_len}) lo_b = 8'd0;
      end
      beat_sum = oc_add(beat_sum, {hi_b, lo_b});
    end
  end

  assign csum_acc = oc_add((st_reg == ST_IDLE) ? ip_psum_i : csum_reg, beat_sum);
  assign csum_fld = {hdr_now[8*UDP_OFF_CSUM +: 8], hdr_now[8*UDP_OFF_CSUM+8 +: 8]};
  // A zero checksum field means the sender did not compute one
  assign csum_bad = (csum_fld != 16'd0) && (csum_acc != 16'hFFFF);
  assign unused_csum = ^{hdr_now[15:0]};

  // Running checksum over pseudo-header, UDP header and payload
  always_ff @(posedge clk) begin
    if (!nreset)
      csum_reg <= 16'd0;
    else if (!cancel_i && (hdr_beat || in_data))
      csum_reg <= csum_acc;
  end
`else
  logic unused_csum;
  assign csum_bad    = 1'b0;
  assign unused_csum = ^{ip_psum_i, hdr_now[15:0], hdr_now[63:48]};
`endif

  // Forward payload beats combinationally; header and drain beats are swallowed
  always_comb begin
    valid_o = 1'b0;
    start_o = 1'b0;
    last_o  = 1'b0;
    err_o   = 1'b0;
    len_o   = len_i;
    if (nreset && !cancel_i) begin
      if (in_data) begin
        valid_o = 1'b1;
        start_o = first_reg;
        if (reach) begin
          last_o = 1'b1;
          len_o  = LEN_W'(udp_len - cnt_reg);
          err_o  = err_reg || ip_cs_err_i || csum_bad;
        end else if (last_i) begin
          last_o = 1'b1;
          err_o  = 1'b1;
        end
      end else if (hdr_done && last_i && go_data) begin
        // IP payload ended exactly at the header although data was promised
        valid_o = 1'b1;
        start_o = 1'b1;
        last_o  = 1'b1;
        err_o   = 1'b1;
      end
    end
  end

  assign data_o = data_i;
  assign ch_o   = hdr_beat ? ch_m : ch_reg;

  // Packet FSM and per-packet context
  always_ff @(posedge clk) begin
    if (!nreset) begin
      st_reg    <= ST_IDLE;
      cnt_reg   <= 16'd0;
      hdr_reg   <= 64'd0;
      ch_reg    <= '0;
      first_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else if (cancel_i) begin
      st_reg    <= ST_IDLE;
      first_reg <= 1'b0;
    end else if (valid_i) begin
      case (st_reg)
        ST_IDLE, ST_HEAD: begin
          if (hdr_beat) begin
            cnt_reg <= cnt_next;
            hdr_reg <= hdr_now;
            err_reg <= hdr_err;
            if (last_i) begin
              st_reg <= ST_IDLE;
            end else if (hdr_done) begin
              if (go_data) begin
                st_reg    <= ST_DATA;
                ch_reg    <= ch_m;
                first_reg <= 1'b1;
              end else begin
                st_reg <= ST_DRAIN;
              end
            end else begin
              st_reg <= ST_HEAD;
            end
          end
        end
        ST_DATA: begin
          cnt_reg   <= cnt_next;
          first_reg <= 1'b0;
          err_reg   <= err_reg || ip_cs_err_i;
          if (last_i)     st_reg <= ST_IDLE;
          else if (reach) st_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (last_i) st_reg <= ST_IDLE;
        end
        default: st_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_mp.sv
// Scoreboard bench for udp_rx_mp: a 16-bit and a 32-bit instance share one
// port table; expected payload beats are queued when a packet is sent and
// checked as each DUT emits valid_o.
module tb_udp_rx_mp;
  import udp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic [15:0] ip_psum;
  logic [63:0] tbl;
  logic [3:0]  en;

  logic        cancel16, valid16, start16, last16, cserr16;
  logic [15:0] data16;
  logic [1:0]  len16;
  logic        vo16, so16, lo16, eo16;
  logic [15:0] do16;
  logic [1:0]  leno16, cho16;

  logic        cancel32, valid32, start32, last32, cserr32;
  logic [31:0] data32;
  logic [2:0]  len32;
  logic        vo32, so32, lo32, eo32;
  logic [31:0] do32;
  logic [2:0]  leno32;
  logic [1:0]  cho32;

  typedef struct {
    logic [31:0] data;
    int          len;
    logic        start;
    logic        last;
    logic        err;
    int          ch;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;
  logic [7:0] pkt[$];
  int n_checks = 0;
  int n_fail   = 0;

  udp_rx_mp #(.DATA_W(16)) dut16 (
    .clk(clk), .nreset(nreset), .cancel_i(cancel16), .valid_i(valid16),
    .start_i(start16), .last_i(last16), .data_i(data16), .len_i(len16),
    .ip_cs_err_i(cserr16), .ip_psum_i(ip_psum), .port_tbl_i(tbl), .port_en_i(en),
    .valid_o(vo16), .start_o(so16), .last_o(lo16), .data_o(do16), .len_o(leno16),
    .ch_o(cho16), .err_o(eo16)
  );

  udp_rx_mp #(.DATA_W(32)) dut32 (
    .clk(clk), .nreset(nreset), .cancel_i(cancel32), .valid_i(valid32),
    .start_i(start32), .last_i(last32), .data_i(data32), .len_i(len32),
    .ip_cs_err_i(cserr32), .ip_psum_i(ip_psum), .port_tbl_i(tbl), .port_en_i(en),
    .valid_o(vo32), .start_o(so32), .last_o(lo32), .data_o(do32), .len_o(leno32),
    .ch_o(cho32), .err_o(eo32)
  );

  // Scoreboard for the 16-bit instance
  always @(negedge clk) begin
    if (nreset === 1'b1 && vo16 === 1'b1) begin
      n_checks++;
      if (q16.size() == 0) begin
        n_fail++;
        $display("FAIL beat16: unexpected valid_o data=%h len=%0d last=%b err=%b", do16, leno16, lo16, eo16);
      end else begin
        e16 = q16.pop_front();
        if (do16 !== e16.data[15:0] || leno16 !== 2'(e16.len) || so16 !== e16.start ||
            lo16 !== e16.last || eo16 !== e16.err || cho16 !== 2'(e16.ch)) begin
          n_fail++;
          $display("FAIL beat16: got data=%h len=%0d s=%b l=%b e=%b ch=%0d, want data=%h len=%0d s=%b l=%b e=%b ch=%0d",
                   do16, leno16, so16, lo16, eo16, cho16,
                   e16.data[15:0], e16.len, e16.start, e16.last, e16.err, e16.ch);
        end else begin
          $display("beat16 data=%h len=%0d start=%b last=%b err=%b ch=%0d", do16, leno16, so16, lo16, eo16, cho16);
        end
      end
    end
  end

  // Scoreboard for the 32-bit instance
  always @(negedge clk) begin
    if (nreset === 1'b1 && vo32 === 1'b1) begin
      n_checks++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL beat32: unexpected valid_o data=%h len=%0d last=%b err=%b", do32, leno32, lo32, eo32);
      end else begin
        e32 = q32.pop_front();
        if (do32 !== e32.data || leno32 !== 3'(e32.len) || so32 !== e32.start ||
            lo32 !== e32.last || eo32 !== e32.err || cho32 !== 2'(e32.ch)) begin
          n_fail++;
          $display("FAIL beat32: got data=%h len=%0d s=%b l=%b e=%b ch=%0d, want data=%h len=%0d s=%b l=%b e=%b ch=%0d",
                   do32, leno32, so32, lo32, eo32, cho32,
                   e32.data, e32.len, e32.start, e32.last, e32.err, e32.ch);
        end else begin
          $display("beat32 data=%h len=%0d start=%b last=%b err=%b ch=%0d", do32, leno32, so32, lo32, eo32, cho32);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] oc(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Ones'-complement sum of pseudo-header and the first ulen datagram bytes
  function automatic logic [15:0] pkt_sum(input int ulen);
    logic [15:0] s;
    logic [7:0]  lo;
    s = ip_psum;
    for (int i = 0; i < ulen; i += 2) begin
      lo = (i + 1 < ulen) ? pkt[i+1] : 8'd0;
      s = oc(s, {pkt[i], lo});
    end
    return s;
  endfunction

  task automatic idle_all();
    valid16 = 0; start16 = 0; last16 = 0; cancel16 = 0; cserr16 = 0; data16 = '0; len16 = '0;
    valid32 = 0; start32 = 0; last32 = 0; cancel32 = 0; cserr32 = 0; data32 = '0; len32 = '0;
  endtask

  task automatic build_pkt(input int dst, input int ulen, input int csum, input int ip_total);
    pkt.delete();
    for (int i = 0; i < ip_total; i++) begin
      case (i)
        0: pkt.push_back(8'h12);
        1: pkt.push_back(8'h34);
        2: pkt.push_back(dst[15:8]);
        3: pkt.push_back(dst[7:0]);
        4: pkt.push_back(ulen[15:8]);
        5: pkt.push_back(ulen[7:0]);
        6: pkt.push_back(csum[15:8]);
        7: pkt.push_back(csum[7:0]);
        default: pkt.push_back(8'(i * 7 + 3));
      endcase
    end
  endtask

  // Queue the payload beats the spec says the parser must emit for pkt
  task automatic push_exp(input int dw, input int ch, input bit hit, input bit extra_err, input int max_beats);
    int kw, n, ulen, endb, nb;
    exp_t e;
    kw = dw / 8;
    n = pkt.size();
    ulen = {pkt[4], pkt[5]};
    if (!hit || ulen <= 8) return;
    endb = (ulen < n) ? ulen : n;
    nb = 0;
    for (int off = 8; off < endb; off += kw) begin
      if (max_beats >= 0 && nb >= max_beats) break;
      e.data = '0;
      for (int j = 0; j < kw; j++)
        if (off + j < n) e.data[8*j +: 8] = pkt[off+j];
      e.len   = (endb - off < kw) ? endb - off : kw;
      e.start = (off == 8);
      e.last  = (off + kw >= endb) && (max_beats < 0);
      e.err   = e.last && ((n < ulen) || extra_err);
      e.ch    = ch;
      if (dw == 16) q16.push_back(e); else q32.push_back(e);
      nb++;
    end
  endtask

  task automatic send(input int dw, input int cancel_at, input int cserr_at, input bit no_gap);
    int kw, n, nb, l;
    logic [31:0] d;
    kw = dw / 8;
    n = pkt.size();
    nb = (n + kw - 1) / kw;
    $display("pkt dw=%0d dst=%0d ulen=%0d bytes=%0d cancel_at=%0d", dw, {pkt[2], pkt[3]}, {pkt[4], pkt[5]}, n, cancel_at);
    for (int i = 0; i < nb; i++) begin
      d = '0;
      l = 0;
      for (int j = 0; j < kw; j++)
        if (i * kw + j < n) begin
          d[8*j +: 8] = pkt[i*kw+j];
          l++;
        end
      @(posedge clk); #1;
      if (dw == 16) begin
        valid16 = 1; start16 = (i == 0); last16 = (i == nb - 1); data16 = d[15:0];
        len16 = 2'(l); cancel16 = (i == cancel_at); cserr16 = (i == cserr_at);
      end else begin
        valid32 = 1; start32 = (i == 0); last32 = (i == nb - 1); data32 = d;
        len32 = 3'(l); cancel32 = (i == cancel_at); cserr32 = (i == cserr_at);
      end
      if (i == cancel_at) break;
    end
    if (!no_gap) begin
      @(posedge clk); #1;
      idle_all();
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    nreset = 0;
    idle_all();
    valid16 = 1; start16 = 1; last16 = 1; len16 = 2'd2;
    valid32 = 1; start32 = 1; last32 = 1; len32 = 3'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({vo16, so16, lo16, eo16} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out16: got v/s/l/e=%b%b%b%b want 0000", vo16, so16, lo16, eo16);
    end
    n_checks++;
    if ({vo32, so32, lo32, eo32} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out32: got v/s/l/e=%b%b%b%b want 0000", vo32, so32, lo32, eo32);
    end
    @(posedge clk); #1;
    idle_all();
    nreset = 1;
    @(negedge clk);
    n_checks++;
    if (dut16.st_reg !== ST_IDLE || dut32.st_reg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %b/%b want %b", dut16.st_reg, dut32.st_reg, ST_IDLE);
    end
    n_checks++;
    if ({vo16, vo32, cho16, cho32} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got vo16=%b vo32=%b ch16=%0d ch32=%0d want all 0", vo16, vo32, cho16, cho32);
    end
  endtask

  task automatic test_basic16();
    build_pkt(18070, 14, 0, 14);
    push_exp(16, 2, 1, 0, -1);
    n_checks++;
    if (q16.size() != 3) begin
      n_fail++;
      $display("FAIL basic16_beats: model queued %0d beats, require 3", q16.size());
    end
    send(16, -1, -1, 0);
    n_checks++;
    if (q16.size() != 0) begin
      n_fail++;
      $display("FAIL basic16_missing: %0d beats never emitted, require 0", q16.size());
      q16.delete();
    end
  endtask

  task automatic test_nomatch();
    build_pkt(1234, 14, 0, 14);
    push_exp(16, 0, 0, 0, -1);
    send(16, -1, -1, 0);
    n_checks++;
    if (dut16.st_reg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL nomatch_state: got %b want %b", dut16.st_reg, ST_IDLE);
    end
  endtask

  task automatic test_pad32();
    build_pkt(18070, 13, 0, 20);
    push_exp(32, 2, 1, 0, -1);
    send(32, -1, -1, 0);
    n_checks++;
    if (q32.size() != 0 || dut32.st_reg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL pad32_end: %0d beats left, state %b, require 0 and %b", q32.size(), dut32.st_reg, ST_IDLE);
      q32.delete();
    end
  endtask

  task automatic test_cancel();
    build_pkt(18070, 16, 0, 16);
    push_exp(16, 2, 1, 0, 1);
    send(16, 5, -1, 0);
    n_checks++;
    if (q16.size() != 0 || dut16.st_reg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL cancel_end: %0d beats left, state %b, require 0 and %b", q16.size(), dut16.st_reg, ST_IDLE);
      q16.delete();
    end
    build_pkt(80, 12, 0, 12);
    push_exp(16, 0, 1, 0, -1);
    send(16, -1, -1, 0);
    n_checks++;
    if (q16.size() != 0) begin
      n_fail++;
      $display("FAIL cancel_next: %0d beats never emitted, require 0", q16.size());
      q16.delete();
    end
  endtask

  task automatic test_trunc();
    build_pkt(18070, 20, 0, 10);
    push_exp(16, 2, 1, 0, -1);
    send(16, -1, -1, 0);
    n_checks++;
    if (q16.size() != 0) begin
      n_fail++;
      $display("FAIL trunc_missing: %0d beats never emitted, require 0", q16.size());
      q16.delete();
    end
  endtask

  task automatic test_priority32();
    build_pkt(80, 12, 0, 12);
    push_exp(32, 0, 1, 0, -1);
    send(32, -1, -1, 0);
    en = 4'b1111;
    build_pkt(18070, 14, 0, 16);
    push_exp(32, 1, 1, 0, -1);
    send(32, -1, -1, 0);
    en = 4'b1101;
    n_checks++;
    if (q32.size() != 0) begin
      n_fail++;
      $display("FAIL priority32_missing: %0d beats never emitted, require 0", q32.size());
      q32.delete();
    end
  endtask

  task automatic test_ip_cs_err();
    build_pkt(18070, 12, 0, 12);
    push_exp(16, 2, 0, 0, -1);
    send(16, -1, 1, 0);
    build_pkt(18070, 14, 0, 14);
    push_exp(16, 2, 1, 1, -1);
    send(16, -1, 4, 0);
    n_checks++;
    if (q16.size() != 0) begin
      n_fail++;
      $display("FAIL ipcs_missing: %0d beats never emitted, require 0", q16.size());
      q16.delete();
    end
  endtask

  task automatic test_back_to_back();
    build_pkt(18070, 8, 0, 8);
    push_exp(32, 2, 1, 0, -1);
    send(32, -1, -1, 1);
    build_pkt(18070, 16, 0, 16);
    push_exp(32, 2, 1, 0, -1);
    send(32, -1, -1, 1);
    build_pkt(80, 10, 0, 12);
    push_exp(32, 0, 1, 0, -1);
    send(32, -1, -1, 0);
    n_checks++;
    if (q32.size() != 0 || dut32.st_reg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL b2b_end: %0d beats left, state %b, require 0 and %b", q32.size(), dut32.st_reg, ST_IDLE);
      q32.delete();
    end
  endtask

`ifdef UDP_CSUM_EN
  task automatic test_csum();
    logic [15:0] good;
    build_pkt(18070, 13, 0, 14);
    good = ~pkt_sum(13);
    pkt[6] = good[15:8];
    pkt[7] = good[7:0];
    push_exp(16, 2, 1, 0, -1);
    send(16, -1, -1, 0);
    good = good + 16'd1;
    pkt[6] = good[15:8];
    pkt[7] = good[7:0];
    push_exp(16, 2, 1, 1, -1);
    send(16, -1, -1, 0);
    pkt[6] = 8'd0;
    pkt[7] = 8'd0;
    push_exp(16, 2, 1, 0, -1);
    send(16, -1, -1, 0);
    n_checks++;
    if (q16.size() != 0) begin
      n_fail++;
      $display("FAIL csum_missing: %0d beats never emitted, require 0", q16.size());
      q16.delete();
    end
  endtask
`endif

  initial begin
    ip_psum = 16'h1A2B;
    tbl = {16'd80, 16'd18070, 16'd18070, 16'd80};
    en = 4'b1101;
    idle_all();
    nreset = 0;
    test_reset();
    test_basic16();
    test_nomatch();
    test_pad32();
    test_cancel();
    test_trunc();
    test_priority32();
    test_ip_cs_err();
    test_back_to_back();
`ifdef UDP_CSUM_EN
    test_csum();
`endif
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
